// File: rtl/codecracker_led_pwm.sv
// codecracker_led_pwm: Avalon-MM slave driving WIDTH LED channels, with
// atomic set/clear ports, per-channel blink mode and global PWM brightness.
// Optional feature macro: LED_PWM_EN. When it is defined, the PWM counter,
// the DUTY register and the STATUS pwm_cnt field are present. Without it,
// LEDs are never dimmed, DUTY reads 0 and STATUS shows only the blink phase.
module codecracker_led_pwm #(
  parameter int WIDTH     = 10,
  parameter int PWM_BITS  = 8,
  parameter int BLINK_DIV = 25000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam int                  PRESC_W    = $clog2(BLINK_DIV);
  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(BLINK_DIV - 1);
  localparam logic [PWM_BITS-1:0] DUTY_ONES  = {PWM_BITS{1'b1}};

  logic                wr_en;
  logic [WIDTH-1:0]    wr_bits;
  logic [WIDTH-1:0]    data_q, data_d;
  logic [WIDTH-1:0]    mode_q, mode_d;
  logic [WIDTH-1:0]    out_q, out_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic                blink_phase_q, blink_phase_d;
  logic                pwm_on;
  logic [PWM_BITS-1:0] duty_field;
  logic [PWM_BITS-1:0] pwm_field;
  logic                unused_wd;

  assign wr_en     = chipselect && !write_n;
  assign wr_bits   = writedata[WIDTH-1:0];
  // Upper write-data bits beyond the channel count carry no meaning.
  assign unused_wd = ^writedata;

  // Decode bus writes into next values of DATA and MODE (set/clear are atomic).
  always_comb begin
    data_d = data_q;
    mode_d = mode_q;
    if (wr_en) begin
      case (address)
        3'd0:    data_d = wr_bits;
        3'd1:    data_d = data_q | wr_bits;
        3'd2:    data_d = data_q & ~wr_bits;
        3'd3:    mode_d = wr_bits;
        default: ;
      endcase
    end
  end

  // Free-running blink prescaler; the phase flips each time it wraps.
  always_comb begin
    presc_d       = presc_q + PRESC_W'(1);
    blink_phase_d = blink_phase_q;
    if (presc_q == PRESC_LAST) begin
      presc_d       = '0;
      blink_phase_d = ~blink_phase_q;
    end
  end

`ifdef LED_PWM_EN
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [PWM_BITS-1:0] duty_q, duty_d;

  // DUTY is written only through its own address.
  always_comb begin
    duty_d = duty_q;
    if (wr_en && (address == 3'd4)) begin
      duty_d = writedata[PWM_BITS-1:0];
    end
  end

  // PWM counter wraps naturally at its width; DUTY resets to full brightness.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt_q <= '0;
      duty_q    <= DUTY_ONES;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
      duty_q    <= duty_d;
    end
  end

  // All-ones duty must be fully on, so it is special-cased past the compare.
  assign pwm_on     = (pwm_cnt_q < duty_q) || (duty_q == DUTY_ONES);
  assign duty_field = duty_q;
  assign pwm_field  = pwm_cnt_q;
`else
  assign pwm_on     = 1'b1;
  assign duty_field = '0;
  assign pwm_field  = '0;
`endif

  // LED drive is computed from registered state, giving one cycle of latency.
  assign out_d = data_q & {WIDTH{pwm_on}} & (~mode_q | {WIDTH{blink_phase_q}});

  // Register file, blink state and LED output register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q        <= '0;
      mode_q        <= '0;
      presc_q       <= '0;
      blink_phase_q <= 1'b0;
      out_q         <= '0;
    end else begin
      data_q        <= data_d;
      mode_q        <= mode_d;
      presc_q       <= presc_d;
      blink_phase_q <= blink_phase_d;
      out_q         <= out_d;
    end
  end

  assign out_port = out_q;

  // Zero-latency readback of register contents, zero-extended to 32 bits.
  always_comb begin
    readdata = '0;
    case (address)
      3'd0, 3'd1, 3'd2: readdata[WIDTH-1:0] = data_q;
      3'd3:             readdata[WIDTH-1:0] = mode_q;
      3'd4:             readdata[PWM_BITS-1:0] = duty_field;
      3'd5: begin
        readdata[0]            = blink_phase_q;
        readdata[PWM_BITS+7:8] = pwm_field;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_codecracker_led_pwm.sv
// tb_codecracker_led_pwm: directed self-checking bench for the LED controller
// with WIDTH=10, PWM_BITS=4, BLINK_DIV=4. Expected PWM-related values follow
// whether LED_PWM_EN is defined for the build.
module tb_codecracker_led_pwm;

  localparam int WIDTH     = 10;
  localparam int PWM_BITS  = 4;
  localparam int BLINK_DIV = 4;
`ifdef LED_PWM_EN
  localparam bit PWM_EN = 1'b1;
`else
  localparam bit PWM_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [2:0]       address = 3'd0;
  logic             chipselect = 1'b0;
  logic             write_n = 1'b1;
  logic [31:0]      writedata = 32'd0;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] out_port;

  int testCount = 0;
  int failCount = 0;
  int edgeCnt = 0;

  codecracker_led_pwm #(
    .WIDTH(WIDTH),
    .PWM_BITS(PWM_BITS),
    .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .out_port(out_port)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Reference count of clock edges since reset release, used to predict counters.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) edgeCnt <= 0;
    else          edgeCnt <= edgeCnt + 1;
  end

  // Abort guard so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single bus write, captured at the posedge; returns 1ns after that edge.
  task automatic applyStimulus(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  // Combinational read; no clock edge is consumed.
  task automatic readReg(input logic [2:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  // One comparison point.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Expected STATUS word for the current edge count.
  function automatic logic [31:0] statusModel(input int k);
    logic [31:0] s;
    s = 32'd0;
    s[0] = ((k / BLINK_DIV) % 2) != 0;
    if (PWM_EN) s[11:8] = 4'(k % 16);
    return s;
  endfunction

  initial begin
    logic [31:0] r;
    logic [31:0] resetExp [8];
    int          highCnt;
    int          dutyVals [3];
    int          dutyHigh [3];

    resetExp = '{32'h0, 32'h0, 32'h0, 32'h0,
                 (PWM_EN ? 32'hF : 32'h0), 32'h0, 32'h0, 32'h0};
    dutyVals = '{4, 0, 15};
    dutyHigh = '{(PWM_EN ? 4 : 16), (PWM_EN ? 0 : 16), 16};

    // Reset state of every address and of the LED drive.
    #23;
    for (int a = 0; a < 8; a++) begin
      readReg(3'(a), r);
      checkOutput($sformatf("reset_rd%0d", a), r, resetExp[a]);
    end
    checkOutput("reset_out", 32'(out_port), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // DATA write: register updates at the edge, LEDs one edge later.
    applyStimulus(3'd0, 32'h3FF);
    checkOutput("out_same_edge", 32'(out_port), 32'h0);
    readReg(3'd0, r);
    checkOutput("data_rd", r, 32'h3FF);
    @(posedge clk);
    #1;
    checkOutput("out_next_edge", 32'(out_port), 32'h3FF);

    // Upper write bits are dropped and read back as zero.
    applyStimulus(3'd0, 32'hFFFF_FFFF);
    readReg(3'd0, r);
    checkOutput("data_upper_zero", r, 32'h3FF);

    // Writes to STATUS and unmapped addresses have no effect.
    applyStimulus(3'd5, 32'h0);
    applyStimulus(3'd6, 32'h0);
    applyStimulus(3'd7, 32'h0);
    readReg(3'd0, r);
    checkOutput("ignored_wr_data", r, 32'h3FF);
    readReg(3'd6, r);
    checkOutput("addr6_rd", r, 32'h0);

    // Atomic set and clear.
    applyStimulus(3'd0, 32'h0F0);
    applyStimulus(3'd1, 32'h00F);
    readReg(3'd0, r);
    checkOutput("outset_data", r, 32'h0FF);
    readReg(3'd1, r);
    checkOutput("outset_rd", r, 32'h0FF);
    applyStimulus(3'd2, 32'h030);
    readReg(3'd0, r);
    checkOutput("outclr_data", r, 32'h0CF);
    readReg(3'd2, r);
    checkOutput("outclr_rd", r, 32'h0CF);

    // MODE readback, then back to steady mode.
    applyStimulus(3'd3, 32'hFFFF_FC02);
    readReg(3'd3, r);
    checkOutput("mode_rd", r, 32'h002);
    applyStimulus(3'd3, 32'h0);

    // PWM duty: count high cycles of channel 0 over one full PWM period.
    applyStimulus(3'd0, 32'h001);
    for (int d = 0; d < 3; d++) begin
      applyStimulus(3'd4, 32'(dutyVals[d]));
      readReg(3'd4, r);
      checkOutput($sformatf("duty_rd%0d", dutyVals[d]), r,
                  PWM_EN ? 32'(dutyVals[d]) : 32'h0);
      highCnt = 0;
      for (int c = 0; c < 16; c++) begin
        @(posedge clk);
        #1;
        if (out_port[0]) highCnt++;
      end
      checkOutput($sformatf("pwm_high_duty%0d", dutyVals[d]), 32'(highCnt),
                  32'(dutyHigh[d]));
    end

    // Blink: channel 1 follows the phase one edge late, channel 0 stays on.
    applyStimulus(3'd0, 32'h003);
    applyStimulus(3'd3, 32'h002);
    for (int c = 0; c < 16; c++) begin
      @(posedge clk);
      #1;
      readReg(3'd5, r);
      checkOutput("blink_status", r, statusModel(edgeCnt));
      checkOutput("blink_ch0", 32'(out_port[0]), 32'h1);
      checkOutput("blink_ch1", 32'(out_port[1]),
                  32'(((edgeCnt - 1) / BLINK_DIV) % 2));
    end

    // Asynchronous reset mid-blink clears the LEDs without a clock edge.
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_rst_out", 32'(out_port), 32'h0);
    readReg(3'd0, r);
    checkOutput("async_rst_data", r, 32'h0);
    readReg(3'd5, r);
    checkOutput("async_rst_status", r, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      readReg(3'd5, r);
      checkOutput("restart_status", r, statusModel(edgeCnt));
      checkOutput("restart_out", 32'(out_port), 32'h0);
    end
    readReg(3'd0, r);
    checkOutput("restart_data", r, 32'h0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/codecracker_led_pwm.md
Name: codecracker_led_pwm

Overview:
- Parametrised successor to the single-register LED PIO. Avalon-MM slave driving WIDTH LED channels.
- Adds atomic set/clear write ports, a per-channel blink mode and a global PWM brightness control.
- Sits between the Nios II data master (via the interconnect) and the board LED pins.

Parameters:
- WIDTH, 10, number of LED channels (1..32).
- PWM_BITS, 8, PWM counter/duty width (2..16).
- BLINK_DIV, 25000000, clk cycles per blink half-period (>=2).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- address  input  3  register word address.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data.
- readdata  output  32  read data, zero-extended, combinational from address.
- out_port  output  WIDTH  registered LED drive.

Behaviour:
- Interface: one clock (clk); reset_n is asynchronous, active-low.
- Write occurs when chipselect && !write_n. Zero wait states; reads have zero latency.
- Register map:
  - 0 DATA (rw): the DATA register.
  - 1 OUTSET (w): DATA |= wd[WIDTH-1:0]. Reads return DATA.
  - 2 OUTCLR (w): DATA &= ~wd. Reads return DATA.
  - 3 MODE (rw): bit i=1 puts channel i in blink mode.
  - 4 DUTY (rw): PWM_BITS-wide duty value.
  - 5 STATUS (r): bit0 = blink_phase, bits[PWM_BITS+7:8] = pwm_cnt.
  - Addresses 6-7: reads return 0, writes are ignored. Writes to 5 are ignored.
- Reset values:
  - DATA=0, MODE=0, DUTY=all ones.
  - pwm_cnt=0, prescaler=0, blink_phase=0, out_port=0.
  - Reset asserted mid-operation forces out_port=0 immediately (async); all state is lost.
- PWM counter:
  - pwm_cnt increments every clk and wraps 2^PWM_BITS-1 -> 0.
  - pwm_on = (pwm_cnt < DUTY) || (DUTY == all ones).
  - DUTY=0 gives always off. DUTY=all ones gives always on.
- Blink:
  - Prescaler counts 0..BLINK_DIV-1. On reaching BLINK_DIV-1 it wraps to 0 and blink_phase toggles.
  - Free-running; not restarted by MODE writes.
- Output:
  - Next-state out_port[i] = DATA[i] & pwm_on & (~MODE[i] | blink_phase), registered.
  - A write at edge N updates the register at N; out_port reflects it at edge N+1 (one-cycle latency).
- Readback: readdata reflects register contents (never out_port) and upper bits are 0.

Optional Feature:
- Macro LED_PWM_EN.
- Defined: PWM counter, DUTY register and STATUS pwm_cnt field are present, as above.
- Undefined: no PWM logic. pwm_on is constant 1, DUTY reads 0 and writes are ignored, STATUS bits[PWM_BITS+7:8] read 0. Blink, set/clear and DATA behaviour are unchanged.

Test Plan (bench uses BLINK_DIV=4, PWM_BITS=4, WIDTH=10, LED_PWM_EN defined):
- Reset then read all addresses -> DATA=0, MODE=0, DUTY=0xF, out_port=0x000.
- Write DATA=0x3FF, then read addr 0 -> 0x3FF. out_port=0x3FF one cycle after the write edge, not on the same edge.
- From DATA=0x0F0: OUTSET 0x00F -> DATA=0x0FF; OUTCLR 0x030 -> DATA=0x0CF. Reads of addr 1/2 return DATA.
- DATA=0x001, DUTY=4 -> out_port[0] high 4 of every 16 cycles. DUTY=0 -> never high. DUTY=0xF -> always high.
- DATA=0x003, MODE=0x002 -> out_port[1] toggles every 4 cycles while out_port[0] stays high. STATUS bit0 tracks the toggles.
- Assert reset_n low mid-blink -> out_port=0 with no clk edge. After release, DATA=0 and phase/counters restart from 0.
